// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between NUM_CH 8-bit status
// sources. A channel is queued when its byte differs from the last byte the
// UART accepted for it, or when the periodic refresh tick fires. Queued
// channels are served round-robin, one byte per grant, with a valid/ready
// handshake toward the UART.
//
// Ports:
//   uart_clk  - block clock (rising edge)
//   rst       - asynchronous active-high reset
//   ch_data   - source bytes, channel i at [8i+7:8i]
//   tx_ready  - UART accepts a byte this cycle
//   tx_valid  - tx_data/tx_id hold a byte offered to the UART
//   tx_data   - offered byte
//   tx_id     - channel index of tx_data
//   pending   - per-channel send-request flags
module uart_tx_scheduler #(
    parameter int unsigned NUM_CH         = 3,
    parameter int unsigned REFRESH_CYCLES = 1000000,
    parameter int unsigned ID_W           = 3
) (
    input  logic                     uart_clk,
    input  logic                     rst,
    input  logic [8*NUM_CH-1:0]      ch_data,
    input  logic                     tx_ready,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    output logic [ID_W-1:0]          tx_id,
    output logic [NUM_CH-1:0]        pending
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t              state, state_d;
    logic [DATA_W-1:0]   shadow [NUM_CH];
    logic [NUM_CH-1:0]   diff;
    logic [NUM_CH-1:0]   pending_d;
    logic [CNT_W-1:0]    cnt;
    logic                tick;
    logic                accept;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
    logic [ID_W-1:0]     grant;
    logic [DATA_W-1:0]   grant_data;
    logic                grant_vld;
    int unsigned         idx;
    logic                tx_valid_d;
    logic [DATA_W-1:0]   tx_data_d;
    logic [ID_W-1:0]     tx_id_d;

    assign accept = (state == SEND) && tx_valid && tx_ready;

    // Refresh counter; frozen at zero when refresh is disabled.
    assign tick = (REFRESH_CYCLES != 0) && (cnt == CNT_W'(REFRESH_CYCLES - 1));

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (REFRESH_CYCLES != 0) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Channel differs from the last byte the UART took for it.
    always_comb begin
        diff = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            diff[i] = (ch_data[DATA_W*i +: DATA_W] != shadow[i]);
        end
    end

    // Tick beats the accept-clear, which beats a diff against the stale shadow.
    always_comb begin
        pending_d = pending;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (tick) begin
                pending_d[i] = 1'b1;
            end else if (accept && (tx_id == ID_W'(i))) begin
                pending_d[i] = 1'b0;
            end else if (diff[i]) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            pending <= '1;
        end else begin
            pending <= pending_d;
        end
    end

    // Shadow captures the byte on the cycle the UART accepts it.
    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (accept && (tx_id == ID_W'(i))) begin
                    shadow[i] <= tx_data;
                end
            end
        end
    end

    // Round-robin pick: first pending channel at offset 0.. from rr_ptr.
    always_comb begin
        grant      = '0;
        grant_data = '0;
        grant_vld  = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            for (int unsigned j = 0; j < NUM_CH; j++) begin
                if (!grant_vld && pending[j] && (idx == j)) begin
                    grant      = ID_W'(j);
                    grant_data = ch_data[DATA_W*j +: DATA_W];
                    grant_vld  = 1'b1;
                end
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        tx_valid_d = tx_valid;
        tx_data_d  = tx_data;
        tx_id_d    = tx_id;
        rr_ptr_d   = rr_ptr;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = grant_data;
                    tx_id_d    = grant;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    tx_valid_d = 1'b0;
                    rr_ptr_d   = (tx_id == ID_W'(NUM_CH - 1)) ? '0 : tx_id + ID_W'(1);
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_id    <= '0;
            rr_ptr   <= '0;
        end else begin
            tx_valid <= tx_valid_d;
            tx_data  <= tx_data_d;
            tx_id    <= tx_id_d;
            rr_ptr   <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: one instance with refresh disabled for the
// change-driven scenarios, one with a 20-cycle refresh for the periodic resend.
module tb_uart_tx_scheduler;

    localparam int unsigned NUM_CH  = 3;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned REFRESH = 20;

    logic                  uart_clk   = 1'b0;
    logic                  rst        = 1'b1;
    logic [8*NUM_CH-1:0]   ch_data    = '0;
    logic [8*NUM_CH-1:0]   ch_data_r  = '0;
    logic                  tx_ready   = 1'b0;
    logic                  tx_ready_r = 1'b0;
    logic                  tx_valid, tx_valid_r;
    logic [7:0]            tx_data, tx_data_r;
    logic [ID_W-1:0]       tx_id, tx_id_r;
    logic [NUM_CH-1:0]     pending, pending_r;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int unsigned cyc;
        int unsigned id;
        logic [7:0]  data;
    } acc_t;

    acc_t        acc_q[$];
    acc_t        acc_r_q[$];
    int unsigned cyc = 0;

    uart_tx_scheduler #(.NUM_CH(NUM_CH), .REFRESH_CYCLES(0), .ID_W(ID_W)) dut (
        .uart_clk(uart_clk), .rst(rst), .ch_data(ch_data), .tx_ready(tx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_id(tx_id), .pending(pending)
    );

    uart_tx_scheduler #(.NUM_CH(NUM_CH), .REFRESH_CYCLES(REFRESH), .ID_W(ID_W)) dut_r (
        .uart_clk(uart_clk), .rst(rst), .ch_data(ch_data_r), .tx_ready(tx_ready_r),
        .tx_valid(tx_valid_r), .tx_data(tx_data_r), .tx_id(tx_id_r), .pending(pending_r)
    );

    always #5 uart_clk = ~uart_clk;

    // Log every handshake with the cycle it happened on.
    always @(posedge uart_clk) begin
        cyc <= cyc + 1;
        if (!rst && tx_valid && tx_ready)
            acc_q.push_back('{cyc: cyc, id: 32'(tx_id), data: tx_data});
        if (!rst && tx_valid_r && tx_ready_r)
            acc_r_q.push_back('{cyc: cyc, id: 32'(tx_id_r), data: tx_data_r});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge uart_clk);
        #1;
    endtask

    function automatic logic [7:0] byte_of(input logic [8*NUM_CH-1:0] v, input int unsigned i);
        return v[8*i +: 8];
    endfunction

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        ch_data    = 24'h30_21_10;
        tx_ready   = 1'b1;
        ch_data_r  = 24'h33_22_11;
        tx_ready_r = 1'b1;
        rst = 1'b1;
        step(2);
        acc_q.delete();
        rst = 1'b0;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || tx_id !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%0b data=%h id=%0d, expected 0/00/0", tx_valid, tx_data, tx_id);
        end
        checks++;
        if (pending !== '1) begin
            failures++;
            $display("FAIL reset_pending: got %b expected %b", pending, {NUM_CH{1'b1}});
        end
        step(20);
        checks++;
        if (acc_q.size() != NUM_CH) begin
            failures++;
            $display("FAIL broadcast_count: got %0d expected %0d", acc_q.size(), NUM_CH);
        end
        for (int unsigned i = 0; i < NUM_CH && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i].id != i || acc_q[i].data !== byte_of(ch_data, i)) begin
                failures++;
                $display("FAIL broadcast_%0d: got id=%0d data=%h expected id=%0d data=%h",
                         i, acc_q[i].id, acc_q[i].data, i, byte_of(ch_data, i));
            end
        end
        checks++;
        if (tx_valid !== 1'b0 || pending !== '0) begin
            failures++;
            $display("FAIL broadcast_quiet: got valid=%0b pending=%b expected 0/000", tx_valid, pending);
        end
    endtask

    task automatic test_single_change();
        int unsigned base;
        base = acc_q.size();
        ch_data[15:8] = 8'h25;
        step(1);
        checks++;
        if (pending[1] !== 1'b1 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL change_pending: got pending[1]=%0b valid=%0b expected 1/0", pending[1], tx_valid);
        end
        step(1);
        checks++;
        if (tx_valid !== 1'b1 || tx_id !== ID_W'(1) || tx_data !== 8'h25) begin
            failures++;
            $display("FAIL change_offer: got valid=%0b id=%0d data=%h expected 1/1/25", tx_valid, tx_id, tx_data);
        end
        step(10);
        checks++;
        if (acc_q.size() != base + 1) begin
            failures++;
            $display("FAIL change_count: got %0d expected %0d", acc_q.size() - base, 1);
        end else begin
            checks++;
            if (acc_q[base].id != 1 || acc_q[base].data !== 8'h25 || tx_valid !== 1'b0) begin
                failures++;
                $display("FAIL change_accept: got id=%0d data=%h expected id=1 data=25", acc_q[base].id, acc_q[base].data);
            end
        end
    endtask

    task automatic test_simultaneous();
        int unsigned base;
        int unsigned exp_ids [NUM_CH];
        exp_ids = '{2, 0, 1};
        base = acc_q.size();
        ch_data = 24'h42_41_40;
        step(20);
        checks++;
        if (acc_q.size() != base + NUM_CH) begin
            failures++;
            $display("FAIL simul_count: got %0d expected %0d", acc_q.size() - base, NUM_CH);
        end
        for (int unsigned i = 0; i < NUM_CH && base + i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[base+i].id != exp_ids[i] || acc_q[base+i].data !== byte_of(ch_data, exp_ids[i])) begin
                failures++;
                $display("FAIL simul_order_%0d: got id=%0d data=%h expected id=%0d data=%h", i,
                         acc_q[base+i].id, acc_q[base+i].data, exp_ids[i], byte_of(ch_data, exp_ids[i]));
            end
        end
    endtask

    task automatic test_stall();
        int unsigned base;
        bit ok;
        base = acc_q.size();
        tx_ready = 1'b0;
        ch_data[7:0] = 8'h10;
        wait_valid(ok);
        checks++;
        if (!ok || tx_id !== ID_W'(0) || tx_data !== 8'h10) begin
            failures++;
            $display("FAIL stall_offer: got valid=%0b id=%0d data=%h expected 1/0/10", tx_valid, tx_id, tx_data);
        end
        ch_data[7:0] = 8'h11;
        for (int n = 0; n < 50; n++) begin
            step(1);
            checks++;
            if (tx_valid !== 1'b1 || tx_id !== ID_W'(0) || tx_data !== 8'h10) begin
                failures++;
                $display("FAIL stall_hold_%0d: got valid=%0b id=%0d data=%h expected 1/0/10", n, tx_valid, tx_id, tx_data);
            end
        end
        tx_ready = 1'b1;
        step(12);
        checks++;
        if (acc_q.size() != base + 2) begin
            failures++;
            $display("FAIL stall_count: got %0d expected 2", acc_q.size() - base);
        end else begin
            checks++;
            if (acc_q[base].id != 0 || acc_q[base].data !== 8'h10 ||
                acc_q[base+1].id != 0 || acc_q[base+1].data !== 8'h11) begin
                failures++;
                $display("FAIL stall_seq: got (%0d,%h)(%0d,%h) expected (0,10)(0,11)",
                         acc_q[base].id, acc_q[base].data, acc_q[base+1].id, acc_q[base+1].data);
            end
        end
    endtask

    task automatic test_refresh();
        int unsigned run_cycles;
        int unsigned exp_count;
        run_cycles = 130;
        ch_data_r  = 24'h33_22_11;
        tx_ready_r = 1'b1;
        rst = 1'b1;
        step(2);
        acc_r_q.delete();
        acc_q.delete();
        rst = 1'b0;
        step(int'(run_cycles));
        // Initial broadcast ends 6 cycles in; each tick at 20k yields accepts by 20k+6.
        exp_count = NUM_CH;
        for (int unsigned k = 1; REFRESH * k + 2 * NUM_CH <= run_cycles; k++)
            exp_count += NUM_CH;
        checks++;
        if (acc_r_q.size() != exp_count) begin
            failures++;
            $display("FAIL refresh_count: got %0d expected %0d", acc_r_q.size(), exp_count);
        end
        for (int unsigned n = 0; n < acc_r_q.size(); n++) begin
            checks++;
            if (acc_r_q[n].id != n % NUM_CH || acc_r_q[n].data !== byte_of(ch_data_r, n % NUM_CH)) begin
                failures++;
                $display("FAIL refresh_item_%0d: got id=%0d data=%h expected id=%0d data=%h", n,
                         acc_r_q[n].id, acc_r_q[n].data, n % NUM_CH, byte_of(ch_data_r, n % NUM_CH));
            end
            if (n % NUM_CH != 0) begin
                checks++;
                if (acc_r_q[n].cyc - acc_r_q[n-1].cyc != 2) begin
                    failures++;
                    $display("FAIL refresh_gap_%0d: got %0d expected 2", n, acc_r_q[n].cyc - acc_r_q[n-1].cyc);
                end
            end else if (n >= 2 * NUM_CH) begin
                checks++;
                if (acc_r_q[n].cyc - acc_r_q[n-NUM_CH].cyc != REFRESH) begin
                    failures++;
                    $display("FAIL refresh_period_%0d: got %0d expected %0d", n,
                             acc_r_q[n].cyc - acc_r_q[n-NUM_CH].cyc, REFRESH);
                end
            end
        end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        tx_ready = 1'b0;
        ch_data[15:8] = 8'h77;
        wait_valid(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL abort_offer: got valid=0 expected 1");
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || pending !== '1) begin
            failures++;
            $display("FAIL abort_async: got valid=%0b pending=%b expected 0/111", tx_valid, pending);
        end
        ch_data  = 24'h30_21_10;
        tx_ready = 1'b1;
        acc_q.delete();
        step(2);
        rst = 1'b0;
        step(20);
        checks++;
        if (acc_q.size() != NUM_CH) begin
            failures++;
            $display("FAIL abort_bcast_count: got %0d expected %0d", acc_q.size(), NUM_CH);
        end
        for (int unsigned i = 0; i < NUM_CH && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i].id != i || acc_q[i].data !== byte_of(ch_data, i)) begin
                failures++;
                $display("FAIL abort_bcast_%0d: got id=%0d data=%h expected id=%0d data=%h",
                         i, acc_q[i].id, acc_q[i].data, i, byte_of(ch_data, i));
            end
        end
    endtask

    task automatic test_random();
        logic [255:0] seen [NUM_CH];
        logic [7:0]   last [NUM_CH];
        bit           stalled;
        logic [7:0]   held_data;
        logic [ID_W-1:0] held_id;
        int unsigned  c;
        logic [7:0]   v;
        tx_ready = 1'b1;
        step(5);
        acc_q.delete();
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            seen[i] = '0;
            seen[i][byte_of(ch_data, i)] = 1'b1;
            last[i] = byte_of(ch_data, i);
        end
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0) begin
                c = $urandom_range(NUM_CH - 1);
                v = 8'($urandom_range(255));
                ch_data[8*c +: 8] = v;
                seen[c][v] = 1'b1;
            end
            tx_ready  = ($urandom_range(9) < 7);
            stalled   = tx_valid && !tx_ready;
            held_data = tx_data;
            held_id   = tx_id;
            step(1);
            if (stalled) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== held_data || tx_id !== held_id) begin
                    failures++;
                    $display("FAIL rand_hold_%0d: got valid=%0b id=%0d data=%h expected 1/%0d/%h",
                             n, tx_valid, tx_id, tx_data, held_id, held_data);
                end
            end
        end
        tx_ready = 1'b1;
        step(40);
        for (int unsigned n = 0; n < acc_q.size(); n++) begin
            checks++;
            if (acc_q[n].id >= NUM_CH || !seen[acc_q[n].id][acc_q[n].data]) begin
                failures++;
                $display("FAIL rand_origin_%0d: got id=%0d data=%h expected a value the channel carried",
                         n, acc_q[n].id, acc_q[n].data);
            end else begin
                last[acc_q[n].id] = acc_q[n].data;
            end
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            checks++;
            if (last[i] !== byte_of(ch_data, i)) begin
                failures++;
                $display("FAIL rand_final_%0d: got %h expected %h", i, last[i], byte_of(ch_data, i));
            end
        end
        checks++;
        if (tx_valid !== 1'b0 || pending !== '0) begin
            failures++;
            $display("FAIL rand_quiet: got valid=%0b pending=%b expected 0/000", tx_valid, pending);
        end
    endtask

    initial begin
        test_reset();
        test_single_change();
        test_simultaneous();
        test_stall();
        test_refresh();
        test_reset_mid_send();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single UART transmitter between NUM_CH 8-bit status sources, such as game state, target machine and machine operation. A source is sent only when its value differs from the last value delivered for it, or when a periodic refresh falls due. Pending sources are served in round-robin order. The block sits between the game-logic status registers and the UART TX byte interface, and replaces free-running polling with change-driven, back-pressured transmission.

Parameters:
NUM_CH, 3, number of 8-bit source channels (2..8)
REFRESH_CYCLES, 1000000, uart_clk cycles between forced full refreshes; 0 disables refresh
ID_W, 3, width of tx_id; must be at least ceil(log2(NUM_CH))

Ports:
uart_clk  in  1  block clock; all logic is rising-edge on uart_clk
rst  in  1  asynchronous, active-high reset
ch_data  in  8*NUM_CH  source bytes; channel i occupies bits [8i+7:8i]
tx_ready  in  1  UART can accept a byte this cycle
tx_valid  out  1  tx_data holds a byte offered to the UART
tx_data  out  8  byte offered to the UART
tx_id  out  ID_W  channel index of tx_data
pending  out  NUM_CH  per-channel send-request flags (debug/status)

Behaviour:
- One clock, uart_clk. Reset is asynchronous and active-high; a synchronous deassert is required upstream.
- Reset values:
  - tx_valid=0, tx_data=0, tx_id=0
  - all shadow[i]=0
  - pending = all ones, so a full broadcast follows reset
  - rr_ptr=0, refresh counter=0, state=IDLE
- diff[i] = (ch_data[i] != shadow[i]), combinational; shadow[i] is the last byte accepted by the UART for channel i.
- tick: the refresh counter counts 0..REFRESH_CYCLES-1 and wraps. tick=1 in the wrap cycle. tick is never asserted when REFRESH_CYCLES=0.
- Pending update each cycle:
  - Set term: diff[i] OR tick.
  - Clear term: channel tx_id on an accept cycle.
  - Priority: tick > clear > diff. On the accept cycle, diff against the stale shadow must not re-set the bit; a coinciding tick does re-set it.
- FSM states IDLE and SEND.
- IDLE:
  - If pending is nonzero, grant g = first set bit scanning from rr_ptr upward, wrapping modulo NUM_CH.
  - Register tx_data <= ch_data[g] (value at the grant cycle), tx_id <= g, tx_valid <= 1, go to SEND.
  - Otherwise stay in IDLE with tx_valid=0.
- SEND:
  - tx_valid, tx_data and tx_id are held stable until tx_valid & tx_ready (accept).
  - On accept: tx_valid <= 0, shadow[tx_id] <= tx_data, pending[tx_id] cleared, rr_ptr <= (tx_id+1) mod NUM_CH, go to IDLE.
  - tx_ready low stalls indefinitely with no timeout.
- Latency: a change on ch_data in cycle N sets pending in N+1. If the FSM is in IDLE, tx_valid rises in N+2. Throughput is at most one byte per 2 cycles.
- A source changing while its own byte waits in SEND:
  - The older latched byte is sent.
  - After accept, the shadow holds the old byte, so diff re-sets pending and the new value is sent on a later grant.
  - A change that reverts to the value being sent causes no extra send.
- Multiple changes in the same cycle are all captured in pending and served round-robin; no channel is starved.
- Reset asserted mid-SEND aborts immediately: tx_valid drops asynchronously and all state returns to reset values.

Test Plan:
1. Reset with ch_data={ch2=8'h30, ch1=8'h21, ch0=8'h10}, tx_ready=1, REFRESH_CYCLES=0 -> exactly three accepts, in the order (id0,8'h10), (id1,8'h21), (id2,8'h30); then tx_valid stays 0 and pending=0.
2. Idle system, ch1 changes to 8'h25 at cycle N -> pending[1]=1 at N+1, tx_valid=1 with tx_id=1 and tx_data=8'h25 at N+2, exactly one accept, no further traffic.
3. ch0, ch1 and ch2 change in the same cycle while rr_ptr=2 -> grant order id2, id0, id1.
4. tx_ready held low for 50 cycles during SEND of (id0, 8'h10) while ch0 changes to 8'h11 -> tx_data/tx_id stable for all 50 cycles; 8'h10 is accepted first, then (id0, 8'h11) is sent.
5. REFRESH_CYCLES=20 with inputs static after the initial broadcast -> every 20 cycles all NUM_CH channels are resent with unchanged values, in round-robin order.
6. rst asserted while tx_valid=1 -> tx_valid=0 with no clock edge needed; after release, the full broadcast of test 1 repeats.
